lane_init_fsm: RTL and testbench

//  Lane initialization state machine for the USB4 logical layer: sequences CLd -> Training (TS1, TS2) -> CL0.

---
 rtl/lane_init_pkg.sv | 23 ++
 rtl/sat_event_counter.sv | 29 ++
 rtl/lane_init_fsm.sv | 180 ++++++++++++++++++
 tb/tb_lane_init_fsm.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lane_init_pkg.sv
// Shared encodings, thresholds and counter widths for the lane initialization FSM.
package lane_init_pkg;

   localparam int TS1_RX_REQ   = 2;
   localparam int TS2_RX_REQ   = 2;
   localparam int TS2_TX_MIN   = 16;
   localparam int MAX_RETRY    = 3;

   localparam int LANE_STATE_W = 3;
   localparam int RETRY_W      = 2;
   localparam int TS1_RX_W     = $clog2(TS1_RX_REQ + 1);
   localparam int TS2_RX_W     = $clog2(TS2_RX_REQ + 1);
   localparam int TS2_TX_W     = $clog2(TS2_TX_MIN + 1);

   typedef enum logic [LANE_STATE_W-1:0] {
      ST_DISCONNECTED = 3'd0,
      ST_DISABLED     = 3'd1,
      ST_TRAINING_TS1 = 3'd2,
      ST_TRAINING_TS2 = 3'd3,
      ST_CL0          = 3'd4
   } lane_state_t;

endpackage

// File: rtl/sat_event_counter.sv
// Pulse counter that saturates at THRESH; clear wins over increment.
module sat_event_counter #(
   parameter int THRESH = 2,
   parameter int CNT_W  = $clog2(THRESH + 1)
) (
   input  logic sb_clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic reached
);

   localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge sb_clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != THRESH_C)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign reached = (cnt == THRESH_C);

endmodule

// File: rtl/lane_init_fsm.sv
// Lane initialization FSM: CLd -> TS1 -> TS2 -> CL0 with timer qualifiers and registered outputs.
// Define LANE_INIT_RETRY_EN to count training failures and force DISABLED after MAX_RETRY.
import lane_init_pkg::*;

// state            | meaning
// ST_DISCONNECTED  | no partner; raise sbtx after tdisconnect_tx_min, wait for tconnect_rx_min
// ST_DISABLED      | lane held off by config or exhausted retries
// ST_TRAINING_TS1  | sending TS1, waiting for TS1_RX_REQ received TS1
// ST_TRAINING_TS2  | sending TS2, waiting for TS2 rx and tx thresholds
// ST_CL0           | lane operational
module lane_init_fsm (
   input  logic                    sb_clk,
   input  logic                    rst,
   input  logic                    lane_disable,
   input  logic                    sbrx,
   input  logic                    ts1_rcvd,
   input  logic                    ts2_rcvd,
   input  logic                    ts2_sent,
   input  logic                    tdisconnect_tx_min,
   input  logic                    tdisconnect_rx_min,
   input  logic                    tconnect_rx_min,
   input  logic                    tdisabled_min,
   input  logic                    ttraining_error_timeout,
   input  logic                    tgen4_ts1_timeout,
   input  logic                    tgen4_ts2_timeout,
   output logic                    sbtx,
   output logic                    disconnected_s,
   output logic                    fsm_disabled,
   output logic                    fsm_training,
   output logic                    ts1_gen4_s,
   output logic                    ts2_gen4_s,
   output logic                    ts1_send,
   output logic                    ts2_send,
   output logic                    cl0_s,
   output logic [LANE_STATE_W-1:0] lane_state,
   output logic                    training_err,
   output logic [RETRY_W-1:0]      retry_cnt
);

   lane_state_t state_q, state_d;
   logic        sbtx_d;
   logic        fail;
   logic        fail_disable;
   logic        state_change;
   logic        ts1_rx_done, ts2_rx_done, ts2_tx_done;

   // sbrx level is already qualified by the timer; only its flags are used here
   logic        sbrx_unused;
   assign sbrx_unused = sbrx;

   assign state_change = (state_d != state_q);

   sat_event_counter #(.THRESH(TS1_RX_REQ), .CNT_W(TS1_RX_W)) u_ts1_rx (
      .sb_clk  (sb_clk),
      .rst     (rst),
      .clr     (state_change),
      .inc     (ts1_rcvd && (state_q == ST_TRAINING_TS1)),
      .reached (ts1_rx_done)
   );

   sat_event_counter #(.THRESH(TS2_RX_REQ), .CNT_W(TS2_RX_W)) u_ts2_rx (
      .sb_clk  (sb_clk),
      .rst     (rst),
      .clr     (state_change),
      .inc     (ts2_rcvd && (state_q == ST_TRAINING_TS2)),
      .reached (ts2_rx_done)
   );

   sat_event_counter #(.THRESH(TS2_TX_MIN), .CNT_W(TS2_TX_W)) u_ts2_tx (
      .sb_clk  (sb_clk),
      .rst     (rst),
      .clr     (state_change),
      .inc     (ts2_sent && (state_q == ST_TRAINING_TS2)),
      .reached (ts2_tx_done)
   );

   always_comb begin
      state_d = state_q;
      fail    = 1'b0;
      case (state_q)
         ST_DISCONNECTED: begin
            if (lane_disable)                  state_d = ST_DISABLED;
            else if (sbtx && tconnect_rx_min)  state_d = ST_TRAINING_TS1;
         end
         ST_DISABLED: begin
            if (!lane_disable && tdisabled_min) state_d = ST_DISCONNECTED;
         end
         ST_TRAINING_TS1: begin
            if (lane_disable)                                        state_d = ST_DISABLED;
            else if (tdisconnect_rx_min)                             state_d = ST_DISCONNECTED;
            else if (ttraining_error_timeout || tgen4_ts1_timeout)   fail    = 1'b1;
            else if (ts1_rx_done)                                    state_d = ST_TRAINING_TS2;
         end
         ST_TRAINING_TS2: begin
            if (lane_disable)                                        state_d = ST_DISABLED;
            else if (tdisconnect_rx_min)                             state_d = ST_DISCONNECTED;
            else if (ttraining_error_timeout || tgen4_ts2_timeout)   fail    = 1'b1;
            else if (ts2_rx_done && ts2_tx_done)                     state_d = ST_CL0;
         end
         ST_CL0: begin
            if (lane_disable)            state_d = ST_DISABLED;
            else if (tdisconnect_rx_min) state_d = ST_DISCONNECTED;
         end
         default: state_d = ST_DISCONNECTED;
      endcase
      if (fail) state_d = fail_disable ? ST_DISABLED : ST_DISCONNECTED;
   end

   // A fresh entry into DISCONNECTED always restarts with sbtx low
   always_comb begin
      sbtx_d = 1'b1;
      case (state_d)
         ST_DISCONNECTED: sbtx_d = (state_q == ST_DISCONNECTED) ? (sbtx | tdisconnect_tx_min) : 1'b0;
         ST_DISABLED:     sbtx_d = 1'b0;
         default:         sbtx_d = 1'b1;
      endcase
   end

   always_ff @(posedge sb_clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_DISCONNECTED;
         sbtx           <= 1'b0;
         disconnected_s <= 1'b1;
         fsm_disabled   <= 1'b0;
         fsm_training   <= 1'b0;
         ts1_gen4_s     <= 1'b0;
         ts2_gen4_s     <= 1'b0;
         ts1_send       <= 1'b0;
         ts2_send       <= 1'b0;
         cl0_s          <= 1'b0;
      end else begin
         state_q        <= state_d;
         sbtx           <= sbtx_d;
         disconnected_s <= (state_d == ST_DISCONNECTED);
         fsm_disabled   <= (state_d == ST_DISABLED);
         fsm_training   <= (state_d == ST_TRAINING_TS1) || (state_d == ST_TRAINING_TS2);
         ts1_gen4_s     <= (state_d == ST_TRAINING_TS1);
         ts2_gen4_s     <= (state_d == ST_TRAINING_TS2);
         ts1_send       <= (state_d == ST_TRAINING_TS1);
         ts2_send       <= (state_d == ST_TRAINING_TS2);
         cl0_s          <= (state_d == ST_CL0);
      end
   end

   assign lane_state = state_q;

`ifdef LANE_INIT_RETRY_EN
   localparam logic [RETRY_W-1:0] MAX_RETRY_C = RETRY_W'(MAX_RETRY);

   logic [RETRY_W-1:0] retry_q;
   logic [RETRY_W-1:0] retry_inc;
   logic               err_q;
   logic               lane_disable_q;

   assign retry_inc    = (retry_q == MAX_RETRY_C) ? retry_q : retry_q + 1'b1;
   assign fail_disable = (retry_inc == MAX_RETRY_C);

   always_ff @(posedge sb_clk or negedge rst) begin
      if (!rst) begin
         retry_q        <= '0;
         err_q          <= 1'b0;
         lane_disable_q <= 1'b0;
      end else begin
         lane_disable_q <= lane_disable;
         if ((state_d == ST_CL0) && (state_q != ST_CL0)) retry_q <= '0;
         else if (fail)                                  retry_q <= retry_inc;
         if (fail && fail_disable)                 err_q <= 1'b1;
         else if (lane_disable_q && !lane_disable) err_q <= 1'b0;
      end
   end

   assign retry_cnt    = retry_q;
   assign training_err = err_q;
`else
   assign fail_disable = 1'b0;
   assign retry_cnt    = '0;
   assign training_err = 1'b0;
`endif

endmodule

// File: tb/tb_lane_init_fsm.sv
// Directed bench for lane_init_fsm with a cycle-level reference model and literal spot checks.
module tb_lane_init_fsm;

   logic       sb_clk = 1'b0;
   logic       rst = 1'b1;
   logic       lane_disable = 1'b0, sbrx = 1'b0;
   logic       ts1_rcvd = 1'b0, ts2_rcvd = 1'b0, ts2_sent = 1'b0;
   logic       tdisconnect_tx_min = 1'b0, tdisconnect_rx_min = 1'b0, tconnect_rx_min = 1'b0;
   logic       tdisabled_min = 1'b0, ttraining_error_timeout = 1'b0;
   logic       tgen4_ts1_timeout = 1'b0, tgen4_ts2_timeout = 1'b0;
   logic       sbtx, disconnected_s, fsm_disabled, fsm_training, ts1_gen4_s, ts2_gen4_s;
   logic       ts1_send, ts2_send, cl0_s, training_err;
   logic [2:0] lane_state;
   logic [1:0] retry_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   lane_init_fsm dut (
      .sb_clk(sb_clk), .rst(rst), .lane_disable(lane_disable), .sbrx(sbrx),
      .ts1_rcvd(ts1_rcvd), .ts2_rcvd(ts2_rcvd), .ts2_sent(ts2_sent),
      .tdisconnect_tx_min(tdisconnect_tx_min), .tdisconnect_rx_min(tdisconnect_rx_min),
      .tconnect_rx_min(tconnect_rx_min), .tdisabled_min(tdisabled_min),
      .ttraining_error_timeout(ttraining_error_timeout),
      .tgen4_ts1_timeout(tgen4_ts1_timeout), .tgen4_ts2_timeout(tgen4_ts2_timeout),
      .sbtx(sbtx), .disconnected_s(disconnected_s), .fsm_disabled(fsm_disabled),
      .fsm_training(fsm_training), .ts1_gen4_s(ts1_gen4_s), .ts2_gen4_s(ts2_gen4_s),
      .ts1_send(ts1_send), .ts2_send(ts2_send), .cl0_s(cl0_s), .lane_state(lane_state),
      .training_err(training_err), .retry_cnt(retry_cnt)
   );

   always #5 sb_clk = ~sb_clk;

`ifdef LANE_INIT_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: state number, sbtx level, event tallies, retry bookkeeping
   int m_state = 0, m_sbtx = 0, m_c1 = 0, m_c2r = 0, m_c2s = 0;
   int m_retry = 0, m_err = 0, m_ldq = 0, m_nxt = 0;
   bit m_fail = 0;

   always @(posedge sb_clk or negedge rst) begin
      if (!rst) begin
         m_state = 0; m_sbtx = 0; m_c1 = 0; m_c2r = 0; m_c2s = 0;
         m_retry = 0; m_err = 0; m_ldq = 0;
      end else begin
         m_nxt  = m_state;
         m_fail = 0;
         case (m_state)
            0: if (lane_disable) m_nxt = 1; else if (m_sbtx == 1 && tconnect_rx_min) m_nxt = 2;
            1: if (!lane_disable && tdisabled_min) m_nxt = 0;
            2: if (lane_disable) m_nxt = 1; else if (tdisconnect_rx_min) m_nxt = 0;
               else if (ttraining_error_timeout || tgen4_ts1_timeout) m_fail = 1;
               else if (m_c1 >= 2) m_nxt = 3;
            3: if (lane_disable) m_nxt = 1; else if (tdisconnect_rx_min) m_nxt = 0;
               else if (ttraining_error_timeout || tgen4_ts2_timeout) m_fail = 1;
               else if (m_c2r >= 2 && m_c2s >= 16) m_nxt = 4;
            default: if (lane_disable) m_nxt = 1; else if (tdisconnect_rx_min) m_nxt = 0;
         endcase
         if (RETRY_EN) begin
            if (m_ldq == 1 && !lane_disable) m_err = 0;
            if (m_fail) begin
               m_retry = (m_retry < 3) ? m_retry + 1 : 3;
               if (m_retry == 3) begin m_nxt = 1; m_err = 1; end
               else m_nxt = 0;
            end
            if (m_nxt == 4 && m_state != 4) m_retry = 0;
         end else if (m_fail) begin
            m_nxt = 0;
         end
         m_ldq = lane_disable ? 1 : 0;
         if (m_nxt == 0)      m_sbtx = (m_state == 0) ? (m_sbtx | int'(tdisconnect_tx_min)) : 0;
         else if (m_nxt == 1) m_sbtx = 0;
         else                 m_sbtx = 1;
         if (m_nxt != m_state) begin
            m_c1 = 0; m_c2r = 0; m_c2s = 0;
         end else begin
            if (m_state == 2 && ts1_rcvd && m_c1 < 2)  m_c1++;
            if (m_state == 3 && ts2_rcvd && m_c2r < 2) m_c2r++;
            if (m_state == 3 && ts2_sent && m_c2s < 16) m_c2s++;
         end
         m_state = m_nxt;
      end
   end

   logic [14:0] act_v, exp_v;
   always @(negedge sb_clk) begin
      act_v = {lane_state, sbtx, disconnected_s, fsm_disabled, fsm_training, ts1_gen4_s,
               ts2_gen4_s, ts1_send, ts2_send, cl0_s, retry_cnt, training_err};
      exp_v = {3'(m_state), m_sbtx[0], m_state == 0, m_state == 1, m_state == 2 || m_state == 3,
               m_state == 2, m_state == 3, m_state == 2, m_state == 3, m_state == 4,
               2'(m_retry), m_err[0]};
      check("cycle_outputs", int'(act_v), int'(exp_v));
   end

   task automatic cyc();
      @(posedge sb_clk);
      #1;
      ts1_rcvd = 0; ts2_rcvd = 0; ts2_sent = 0;
      tdisconnect_tx_min = 0; tdisconnect_rx_min = 0; tconnect_rx_min = 0;
      tdisabled_min = 0; ttraining_error_timeout = 0;
      tgen4_ts1_timeout = 0; tgen4_ts2_timeout = 0;
   endtask

   task automatic to_ts1();
      tdisconnect_tx_min = 1; cyc();
      tconnect_rx_min = 1; cyc();
   endtask

   task automatic to_ts2();
      to_ts1();
      ts1_rcvd = 1; cyc();
      ts1_rcvd = 1; cyc();
      cyc();
   endtask

   task automatic to_cl0();
      to_ts2();
      ts2_rcvd = 1; ts2_sent = 1; cyc();
      ts2_rcvd = 1; ts2_sent = 1; cyc();
      repeat (14) begin ts2_sent = 1; cyc(); end
      cyc();
   endtask

   initial begin
      #2 rst = 0;
      repeat (3) @(posedge sb_clk);
      #1 rst = 1;

      check("reset_state", lane_state, 0);
      check("reset_disc_s", disconnected_s, 1);
      check("reset_sbtx", sbtx, 0);

      tdisconnect_tx_min = 1; cyc();
      check("sbtx_after_tx_min", sbtx, 1);
      tconnect_rx_min = 1; ts1_rcvd = 1; cyc();
      check("enter_ts1_state", lane_state, 2);
      check("enter_ts1_send", ts1_send, 1);

      ts1_rcvd = 1; cyc(); cyc();
      check("ts1_entry_pulse_ignored", lane_state, 2);
      ts1_rcvd = 1; cyc(); cyc();
      check("enter_ts2", lane_state, 3);

      ts2_rcvd = 1; cyc();
      ts2_rcvd = 1; cyc();
      repeat (15) begin ts2_sent = 1; cyc(); end
      ts1_rcvd = 1; tgen4_ts1_timeout = 1; cyc();
      cyc(); cyc();
      check("ts2_tx_15_stays", lane_state, 3);
      ts2_sent = 1; cyc(); cyc();
      check("enter_cl0", cl0_s, 1);
      check("cl0_state", lane_state, 4);

      tdisconnect_rx_min = 1; cyc();
      check("cl0_rx_min_state", lane_state, 0);
      check("cl0_rx_min_sbtx", sbtx, 0);
      check("cl0_rx_min_retry", retry_cnt, 0);

      for (int i = 1; i <= 3; i++) begin
         to_ts2();
         tgen4_ts2_timeout = 1; cyc();
         if (RETRY_EN) begin
            check("ts2_timeout_retry", retry_cnt, i);
            check("ts2_timeout_state", lane_state, (i < 3) ? 0 : 1);
            check("ts2_timeout_err", training_err, (i < 3) ? 0 : 1);
         end else begin
            check("ts2_timeout_state", lane_state, 0);
            check("ts2_timeout_retry", retry_cnt, 0);
         end
      end

      lane_disable = 1; cyc();
      check("disable_state", fsm_disabled, 1);
      tdisabled_min = 1; cyc();
      check("disabled_hold_while_req", lane_state, 1);
      lane_disable = 0; cyc();
      check("err_cleared_on_fall", training_err, 0);
      tdisabled_min = 1; cyc();
      check("disabled_exit", lane_state, 0);

      to_ts1();
      lane_disable = 1; ts1_rcvd = 1; cyc();
      check("ts1_disable_prio", lane_state, 1);
      check("ts1_disable_send", ts1_send, 0);
      lane_disable = 0; cyc();
      tdisabled_min = 1; cyc();
      check("disable_to_disc", lane_state, 0);

      to_cl0();
      check("second_cl0", lane_state, 4);
      tdisconnect_rx_min = 1; cyc();
      to_ts1();
      ttraining_error_timeout = 1; cyc();
      check("ts1_train_timeout_state", lane_state, 0);
      check("ts1_train_timeout_retry", retry_cnt, RETRY_EN ? 1 : 0);

      to_ts2();
      ts2_rcvd = 1; cyc();
      ts2_sent = 1; cyc();
      rst = 0;
      #2;
      check("async_rst_state", lane_state, 0);
      check("async_rst_disc_s", disconnected_s, 1);
      check("async_rst_ts2_send", ts2_send, 0);
      check("async_rst_retry", retry_cnt, 0);
      @(posedge sb_clk);
      #1 rst = 1;
      to_cl0();
      check("cl0_after_reset", lane_state, 4);
      cyc(); cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
